// File: rtl/ans_stream_decoder.sv
// rANS stream decoder: loads a coder state, then per symbol divides, looks up the ICDF, updates and renormalises.
// Build option ANS_DEC_BINSEARCH_EN selects a fixed-latency binary-search lookup; default is a linear scan.
module ans_stream_decoder #(
   parameter int SYM_WIDTH   = 4,
   parameter int SYM_COUNT   = 16,
   parameter int CNT_WIDTH   = 8,
   parameter int CUM_WIDTH   = 12,
   parameter int STATE_WIDTH = 16,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_flat,
   input  logic [CUM_WIDTH*SYM_COUNT-1:0] cum_flat,
   input  logic                           start,
   input  logic [LEN_WIDTH-1:0]           n_syms,
   input  logic [SYM_WIDTH-1:0]           in_data,
   input  logic                           in_vld,
   output logic                           in_rdy,
   output logic [SYM_WIDTH-1:0]           out_data,
   output logic                           out_vld,
   input  logic                           out_rdy,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);
   localparam int WORDS  = STATE_WIDTH / SYM_WIDTH;
   localparam int IDX_W  = $clog2(SYM_COUNT);
   localparam int STEP_W = $clog2(STATE_WIDTH + SYM_COUNT + 1);
   localparam int PROD_W = STATE_WIDTH + CNT_WIDTH;
`ifdef ANS_DEC_BINSEARCH_EN
   localparam int LK_STEPS = $clog2(SYM_COUNT);
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DIV, S_LOOKUP, S_EMIT, S_UPDATE, S_RENORM
   } state_e;

   state_e                 state_q, state_d;
   logic [STATE_WIDTH-1:0] x_q, x_d;
   logic [CUM_WIDTH-1:0]   rem_q, rem_d;
   logic [STEP_W-1:0]      step_q, step_d;
   logic [IDX_W-1:0]       lo_q, lo_d;
   logic [LEN_WIDTH-1:0]   left_q, left_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
`ifdef ANS_DEC_BINSEARCH_EN
   logic [IDX_W-1:0]       hi_q, hi_d;
   logic [IDX_W:0]         mid_sum;
   logic [IDX_W-1:0]       mid;
`endif

   logic [CNT_WIDTH-1:0]   cnt_a [SYM_COUNT];
   logic [CUM_WIDTH-1:0]   cum_a [SYM_COUNT];
   logic [CUM_WIDTH-1:0]   m, low;
   logic [STATE_WIDTH-1:0] m_ext, x_upd, x_shift;
   logic [CUM_WIDTH:0]     trial, trial_sub;
   logic                   ge;
   logic [IDX_W-1:0]       prev_idx;

   always_comb begin
      for (int i = 0; i < SYM_COUNT; i++) begin
         cnt_a[i] = counts_flat[i*CNT_WIDTH +: CNT_WIDTH];
         cum_a[i] = cum_flat[i*CUM_WIDTH +: CUM_WIDTH];
      end
   end

   assign m        = cum_a[SYM_COUNT-1];
   assign m_ext    = STATE_WIDTH'(m);
   // Restoring divide: x_q shifts the dividend out at the top and the quotient in at the bottom.
   assign trial     = {rem_q, x_q[STATE_WIDTH-1]};
   assign trial_sub = trial - {1'b0, m};
   assign ge        = (trial >= {1'b0, m});
   assign prev_idx  = lo_q - 1'b1;
   assign low       = (lo_q == '0) ? '0 : cum_a[prev_idx];
   assign x_upd     = STATE_WIDTH'(PROD_W'(cnt_a[lo_q]) * PROD_W'(x_q) + PROD_W'(rem_q) - PROD_W'(low));
   assign x_shift   = STATE_WIDTH'({x_q, in_data});
`ifdef ANS_DEC_BINSEARCH_EN
   assign mid_sum   = {1'b0, lo_q} + {1'b0, hi_q};
   assign mid       = IDX_W'(mid_sum >> 1);
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         rem_q   <= '0;
         step_q  <= '0;
         lo_q    <= '0;
         left_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef ANS_DEC_BINSEARCH_EN
         hi_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         rem_q   <= rem_d;
         step_q  <= step_d;
         lo_q    <= lo_d;
         left_q  <= left_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef ANS_DEC_BINSEARCH_EN
         hi_q    <= hi_d;
`endif
      end
   end

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      rem_d   = rem_q;
      step_d  = step_q;
      lo_d    = lo_q;
      left_d  = left_q;
      done_d  = 1'b0;
      err_d   = err_q;
`ifdef ANS_DEC_BINSEARCH_EN
      hi_d    = hi_q;
`endif
      case (state_q)
         S_IDLE: if (start) begin
            err_d  = 1'b0;
            left_d = n_syms;
            step_d = '0;
            if (n_syms == '0) begin
               done_d = 1'b1;
            end else if (m == '0) begin
               err_d  = 1'b1;
               done_d = 1'b1;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: if (in_vld) begin
            x_d[step_q*SYM_WIDTH +: SYM_WIDTH] = in_data;
            step_d = step_q + 1'b1;
            if (step_q == STEP_W'(WORDS - 1)) begin
               state_d = S_DIV;
               rem_d   = '0;
               step_d  = '0;
            end
         end
         S_DIV: begin
            x_d    = {x_q[STATE_WIDTH-2:0], ge};
            rem_d  = ge ? trial_sub[CUM_WIDTH-1:0] : trial[CUM_WIDTH-1:0];
            step_d = step_q + 1'b1;
            if (step_q == STEP_W'(STATE_WIDTH - 1)) begin
               state_d = S_LOOKUP;
               step_d  = '0;
               lo_d    = '0;
`ifdef ANS_DEC_BINSEARCH_EN
               hi_d    = IDX_W'(SYM_COUNT - 1);
`endif
            end
         end
         S_LOOKUP: begin
`ifdef ANS_DEC_BINSEARCH_EN
            if (cum_a[mid] > rem_q) hi_d = mid;
            else                    lo_d = mid + 1'b1;
            step_d = step_q + 1'b1;
            if (step_q == STEP_W'(LK_STEPS - 1)) state_d = S_EMIT;
`else
            if (cum_a[lo_q] > rem_q) state_d = S_EMIT;
            else                     lo_d    = lo_q + 1'b1;
`endif
         end
         S_EMIT: if (out_rdy) begin
            left_d  = left_q - 1'b1;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            x_d = x_upd;
            if (left_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (x_upd < m_ext) begin
               state_d = S_RENORM;
            end else begin
               state_d = S_DIV;
               rem_d   = '0;
               step_d  = '0;
            end
         end
         S_RENORM: if (in_vld) begin
            x_d = x_shift;
            if (x_shift >= m_ext) begin
               state_d = S_DIV;
               rem_d   = '0;
               step_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_rdy   = (state_q == S_LOAD) || (state_q == S_RENORM);
   assign out_vld  = (state_q == S_EMIT);
   assign out_data = SYM_WIDTH'(lo_q);
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ans_stream_decoder.sv
// Self-checking bench for ans_stream_decoder: directed frames plus random tables against an arithmetic rANS model.
module tb_ans_stream_decoder;
   localparam int SW = 4, SC = 4, CW = 8, UW = 12, XW = 16, LW = 16;
   localparam int WORDS = XW / SW;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CW*SC-1:0] counts_flat = '0;
   logic [UW*SC-1:0] cum_flat = '0;
   logic             start = 1'b0;
   logic [LW-1:0]    n_syms = '0;
   logic [SW-1:0]    in_data = '0;
   logic             in_vld = 1'b0;
   logic             in_rdy;
   logic [SW-1:0]    out_data;
   logic             out_vld;
   logic             out_rdy = 1'b1;
   logic             busy, done, err;

   ans_stream_decoder #(
      .SYM_WIDTH(SW), .SYM_COUNT(SC), .CNT_WIDTH(CW),
      .CUM_WIDTH(UW), .STATE_WIDTH(XW), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .counts_flat(counts_flat), .cum_flat(cum_flat),
      .start(start), .n_syms(n_syms), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Owned by the initial block
   int cnt_tab [SC];
   int cum_tab [SC];
   int feed_src [$];
   int stall_len = 0;
   int frame_seq = 0;

   // Owned by the handshake monitor
   int feed_q [$];
   int got_q [$];
   int seen_seq = 0;
   int consumed, done_cnt, stall_cnt, stall_err;
   bit pend_in, held_v, in_rdy_seen, out_vld_seen;
   logic [SW-1:0] held_d;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives the input stream, applies output back-pressure, records transfers (decided on pre-edge values).
   always @(negedge clk) begin
      if (seen_seq != frame_seq) begin
         seen_seq = frame_seq;
         feed_q = feed_src;
         got_q = {};
         consumed = 0; done_cnt = 0; stall_cnt = 0; stall_err = 0;
         pend_in = 1'b0; held_v = 1'b0; in_rdy_seen = 1'b0; out_vld_seen = 1'b0;
      end
      if (pend_in && feed_q.size() > 0) begin
         void'(feed_q.pop_front());
         consumed++;
      end
      in_vld  = (feed_q.size() > 0);
      in_data = in_vld ? SW'(feed_q[0]) : '0;
      pend_in = in_vld && in_rdy;
      if (in_rdy) in_rdy_seen = 1'b1;
      if (done) done_cnt++;
      if (out_vld) begin
         out_vld_seen = 1'b1;
         if (held_v && out_data !== held_d) stall_err++;
         held_v = 1'b1;
         held_d = out_data;
         if (stall_cnt < stall_len) begin
            out_rdy = 1'b0;
            stall_cnt++;
         end else begin
            out_rdy = 1'b1;
            got_q.push_back(int'(out_data));
            held_v = 1'b0;
            stall_cnt = 0;
         end
      end else begin
         out_rdy = (stall_len == 0);
      end
   end

   // Reference rANS decode with plain integer arithmetic.
   task automatic model(input int x0, input int n, input int words[$],
                        output int syms[$], output int used);
      int x, m, q, r, s, low;
      m = cum_tab[SC-1];
      x = x0;
      used = 0;
      syms = {};
      for (int k = 0; k < n; k++) begin
         q = x / m;
         r = x % m;
         s = 0;
         while (s < SC - 1 && cum_tab[s] <= r) s++;
         syms.push_back(s);
         low = (s == 0) ? 0 : cum_tab[s-1];
         x = (cnt_tab[s] * q + r - low) & 'hFFFF;
         if (k == n - 1) break;
         while (x < m && used < words.size()) begin
            x = ((x << SW) | words[used]) & 'hFFFF;
            used++;
         end
      end
   endtask

   task automatic set_tables(input int c0, c1, c2, c3, input int u0, u1, u2, u3);
      cnt_tab = '{c0, c1, c2, c3};
      cum_tab = '{u0, u1, u2, u3};
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_rdy"}, in_rdy, 0);
      check({tag, "_out_vld"}, out_vld, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   task automatic run_frame(input string tag, input int x0, input int n, input int stall,
                            input int first_word, input int abort_at, input bit exp_err,
                            input int exp_cycles);
      int words [$];
      int exp_syms [$];
      int used, cyc, busy_low, exp_cons;
      bit got_done;
      for (int i = 0; i < SC; i++) begin
         counts_flat[i*CW +: CW] = CW'(cnt_tab[i]);
         cum_flat[i*UW +: UW]    = UW'(cum_tab[i]);
      end
      words = {};
      for (int i = 0; i < 48; i++) words.push_back((i == 0 && first_word >= 0) ? first_word : $urandom_range(15));
      used = 0;
      exp_syms = {};
      if (!exp_err && n > 0) model(x0, n, words, exp_syms, used);
      exp_cons = (exp_err || n == 0) ? 0 : WORDS + used;
      feed_src = {};
      for (int w = 0; w < WORDS; w++) feed_src.push_back((x0 >> (w * SW)) & 'hF);
      foreach (words[i]) feed_src.push_back(words[i]);
      stall_len = stall;
      frame_seq++;
      n_syms = LW'(n);
      start = 1'b1;
      got_done = 1'b0;
      busy_low = 0;
      cyc = 0;
      while (cyc < 3000 && !got_done) begin
         @(negedge clk); #1;
         start = 1'b0;
         cyc++;
         if (abort_at != 0 && cyc == abort_at) begin
            check({tag, "_loaded_before_abort"}, consumed, WORDS);
            rst_n = 1'b0;
            feed_src = {};
            frame_seq++;
            #1;
            check_reset_outputs({tag, "_abort"});
            @(negedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         if (done) got_done = 1'b1;
         else if (!busy) busy_low++;
      end
      check({tag, "_done_seen"}, got_done, 1);
      if (exp_cycles > 0) check({tag, "_latency"}, cyc, exp_cycles);
      repeat (3) @(negedge clk);
      #1;
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_words_consumed"}, consumed, exp_cons);
      check({tag, "_busy_during_frame"}, busy_low, 0);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_sym_count"}, got_q.size(), exp_syms.size());
      for (int i = 0; i < exp_syms.size() && i < got_q.size(); i++)
         check($sformatf("%s_sym%0d", tag, i), got_q[i], exp_syms[i]);
      if (stall > 0) check({tag, "_stable_under_stall"}, stall_err, 0);
      if (n == 0 || exp_err) begin
         check({tag, "_in_rdy_never"}, in_rdy_seen, 0);
         check({tag, "_out_vld_never"}, out_vld_seen, 0);
      end
   endtask

   initial begin
      int uni_cycles, m, x0;
`ifdef ANS_DEC_BINSEARCH_EN
      uni_cycles = 5 + 4 * 18 + 4 * 2;
`else
      uni_cycles = 5 + 4 * 18 + (4 + 1 + 3 + 1);
`endif
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk); #1;

      set_tables(1, 1, 1, 1, 1, 2, 3, 4);
      run_frame("uniform", 'h0123, 4, 0, -1, 0, 1'b0, uni_cycles);
      run_frame("backpressure", 'h0123, 4, 10, -1, 0, 1'b0, 0);
      run_frame("zero_len", 'h0123, 0, 0, -1, 0, 1'b0, 1);

      set_tables(5, 1, 1, 1, 5, 6, 7, 8);
      run_frame("renorm", 'h0047, 3, 0, 'hA, 0, 1'b0, 0);

      set_tables(1, 1, 1, 1, 0, 0, 0, 0);
      run_frame("m_zero", 'h0123, 3, 0, -1, 0, 1'b1, 1);
      repeat (5) @(negedge clk);
      #1;
      check("err_sticky", err, 1);
      set_tables(1, 1, 1, 1, 1, 2, 3, 4);
      run_frame("err_clear", 'h0123, 4, 0, -1, 0, 1'b0, uni_cycles);

      run_frame("abort", 'h0123, 4, 0, -1, 8, 1'b0, 0);
      run_frame("after_abort", 'h0123, 4, 0, -1, 0, 1'b0, uni_cycles);

      for (int t = 0; t < 20; t++) begin
         int c [SC];
         int acc;
         acc = 0;
         for (int i = 0; i < SC; i++) c[i] = $urandom_range(20, 1);
         for (int i = 0; i < SC; i++) begin
            acc += c[i];
            cnt_tab[i] = c[i];
            cum_tab[i] = acc;
         end
         m  = cum_tab[SC-1];
         x0 = m + $urandom_range(65535 - m);
         run_frame($sformatf("rand%0d", t), x0, $urandom_range(6, 1), $urandom_range(3), -1, 0, 1'b0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, observed no end expected end");
      $fatal(1, "watchdog");
   end

endmodule
